qspi_cmd_ctrl: RTL

QSPI_CMD_CTRL -- requirements
Module: qspi_cmd_ctrl

---
 rtl/qspi_cmd_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/qspi_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : qspi_cmd_ctrl                                              |
// | Description : Command controller between the qspi block's RX/TX word     |
// |               FIFOs and a simple request/acknowledge memory port. It     |
// |               decodes framed WRITE / READ (and optionally STATUS)        |
// |               commands and moves data words to and from memory.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, rst_n            : clock, asynchronous active-low reset           |
// |   start                 : one-cycle frame-start pulse (ncs falling edge) |
// |   rd_data/valid/ready   : RX fifo word, non-empty flag, pop strobe       |
// |   wr_data/valid/ready   : TX fifo word, has-space flag, push strobe      |
// |   mem_req/we/addr/wdata : memory request, held stable until mem_ack      |
// |   mem_ack/mem_rdata     : memory acknowledge and read data               |
// |   busy                  : controller not idle                            |
// |   err                   : one-cycle protocol-error pulse                 |
// | Frame: word0 = {op[15:12], 3'b0, nresp[8], len[7:0]} (len 0 = 256)       |
// |        word1 = start word address (WRITE / READ only)                    |
// | Build option: define QSPI_CTRL_STATUS_EN to enable the STATUS op and an  |
// |   8-bit saturating error counter; STATUS returns {8'h5A, err_cnt}.       |
// | ADDR_W must not exceed 16 (address comes from one RX word).              |
// +--------------------------------------------------------------------------+
module qspi_cmd_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       rd_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    output logic [15:0]       wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] c_IDLE    = 4'd0;
    localparam logic [3:0] c_HDR     = 4'd1;
    localparam logic [3:0] c_ADDR    = 4'd2;
    localparam logic [3:0] c_WR_DATA = 4'd3;
    localparam logic [3:0] c_WR_MEM  = 4'd4;
    localparam logic [3:0] c_RD_MEM  = 4'd5;
    localparam logic [3:0] c_RD_PUSH = 4'd6;
    localparam logic [3:0] c_DRAIN   = 4'd7;
    localparam logic [3:0] c_ABORT   = 4'd8;
`ifdef QSPI_CTRL_STATUS_EN
    localparam logic [3:0] c_STAT    = 4'd9;
    localparam logic [3:0] c_OP_STATUS = 4'd3;
`endif

    localparam logic [3:0] c_OP_WRITE = 4'd1;
    localparam logic [3:0] c_OP_READ  = 4'd2;

    localparam logic [ADDR_W-1:0] c_ADDR_INC = 1;

    logic [3:0]        r_state;
    logic              r_run;       // set one edge after reset release
    logic              r_is_write;
    logic [ADDR_W-1:0] r_addr;
    logic [8:0]        r_cnt;       // remaining words, 1..256
    logic [15:0]       r_wdata;
    logic [15:0]       r_hold;      // read data / status word awaiting push
    logic              r_err;

    logic              w_start;
    logic              w_rx_state;
    logic              w_hdr_wr;
    logic              w_hdr_rd;
    logic [8:0]        w_len;
    logic              w_last;

    // start is ignored on the first edge after reset release so that the
    // deassertion is seen synchronously before any frame is accepted.
    assign w_start = start & r_run;

    assign w_rx_state = (r_state == c_HDR) || (r_state == c_ADDR) ||
                        (r_state == c_WR_DATA) || (r_state == c_DRAIN);

    // Pops are suppressed in the start cycle: the state is about to be
    // replaced, so a word taken there would be lost.
    assign rd_ready  = rd_valid & ~w_start & w_rx_state;
    assign wr_ready  = wr_valid & ~w_start & (r_state == c_RD_PUSH);

    assign mem_req   = (r_state == c_WR_MEM) || (r_state == c_RD_MEM) ||
                       (r_state == c_ABORT);
    // r_is_write only changes in HDR, so direction stays stable in ABORT.
    assign mem_we    = mem_req & r_is_write;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign wr_data   = r_hold;
    assign busy      = (r_state != c_IDLE);
    assign err       = r_err;

    assign w_hdr_wr = (rd_data[15:12] == c_OP_WRITE) &  rd_data[8];
    assign w_hdr_rd = (rd_data[15:12] == c_OP_READ)  & ~rd_data[8];
    assign w_len    = {(rd_data[7:0] == 8'd0), rd_data[7:0]};
    assign w_last   = (r_cnt == 9'd1);

`ifdef QSPI_CTRL_STATUS_EN
    logic       w_hdr_st;
    logic [7:0] r_err_cnt;

    assign w_hdr_st = (rd_data[15:12] == c_OP_STATUS) & ~rd_data[8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (r_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_run      <= 1'b0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= 9'd0;
            r_wdata    <= 16'd0;
            r_hold     <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_err <= 1'b0;
            if (w_start && mem_req && !mem_ack) begin
                // An outstanding request must finish before the new frame.
                r_state <= c_ABORT;
            end else if (w_start) begin
                r_state <= c_HDR;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_state <= c_IDLE;
                    end
                    c_HDR: begin
                        if (rd_ready) begin
                            r_is_write <= w_hdr_wr;
                            r_cnt      <= w_len;
                            if (w_hdr_wr || w_hdr_rd) begin
                                r_state <= c_ADDR;
                            end
`ifdef QSPI_CTRL_STATUS_EN
                            else if (w_hdr_st) begin
                                r_state <= c_STAT;
                            end
`endif
                            else begin
                                r_state <= c_DRAIN;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                    c_ADDR: begin
                        if (rd_ready) begin
                            r_addr  <= rd_data[ADDR_W-1:0];
                            r_state <= r_is_write ? c_WR_DATA : c_RD_MEM;
                        end
                    end
                    c_WR_DATA: begin
                        if (rd_ready) begin
                            r_wdata <= rd_data;
                            r_state <= c_WR_MEM;
                        end
                    end
                    c_WR_MEM: begin
                        if (mem_ack) begin
                            r_addr  <= r_addr + c_ADDR_INC;
                            r_cnt   <= r_cnt - 9'd1;
                            r_state <= w_last ? c_IDLE : c_WR_DATA;
                        end
                    end
                    c_RD_MEM: begin
                        if (mem_ack) begin
                            r_hold  <= mem_rdata;
                            r_state <= c_RD_PUSH;
                        end
                    end
                    c_RD_PUSH: begin
                        if (wr_ready) begin
                            r_addr  <= r_addr + c_ADDR_INC;
                            r_cnt   <= r_cnt - 9'd1;
                            r_state <= w_last ? c_IDLE : c_RD_MEM;
                        end
                    end
`ifdef QSPI_CTRL_STATUS_EN
                    c_STAT: begin
                        // Status reuses the read push path as a one-word read.
                        r_hold  <= {8'h5A, r_err_cnt};
                        r_cnt   <= 9'd1;
                        r_state <= c_RD_PUSH;
                    end
`endif
                    c_DRAIN: begin
                        r_state <= c_DRAIN;
                    end
                    c_ABORT: begin
                        if (mem_ack) begin
                            r_state <= c_HDR;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
